// File: rtl/aes_key_sched_if.sv
// Bundles the key-schedule load, rcon, round-key stream and store read signals.
// Pure signal container; no logic, no latency.
// No backpressure: the round-key stream must be consumed every cycle it is valid.
interface aes_key_sched_if;
    logic         key_ld;
    logic [127:0] key_in;
    logic         kld_o;
    logic [31:0]  rcon_in;
    logic [127:0] rk_o;
    logic         rk_vld_o;
    logic [3:0]   rk_idx_o;
    logic         busy_o;
    logic         kdone_o;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key_o;

    // Upstream side: drives the key load, rcon word and read index.
    modport master (
        output key_ld, key_in, rcon_in, rd_idx,
        input  kld_o, rk_o, rk_vld_o, rk_idx_o, busy_o, kdone_o, rd_key_o
    );

    // Key schedule side.
    modport slave (
        input  key_ld, key_in, rcon_in, rd_idx,
        output kld_o, rk_o, rk_vld_o, rk_idx_o, busy_o, kdone_o, rd_key_o
    );
endinterface

// File: rtl/aes_key_sched.sv
// AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Purely combinational, zero latency.
// No backpressure.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254 is the inverse for x != 0 and maps 0 to 0, matching the S-box.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] inv;

    // Inverse then affine transform (b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63).
    always_comb begin
        inv = gf_inv(a);
        y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// AES-128 key schedule: streams round keys 0..10 and keeps them in an 11-entry store.
// Key k is presented one cycle after edge Ek; store read port has 1-cycle latency.
// No backpressure: rk_o is valid for 11 back-to-back cycles and must be taken each cycle.
module aes_key_sched #(
    parameter int NRK = 11
) (
    input  logic            clk,
    input  logic            rst,
    aes_key_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    state_t       state;
    logic [127:0] w;
    logic [127:0] w_nxt;
    logic [3:0]   rnd;
    logic         vld;
    logic         busy;
    logic         kdone;
    logic [127:0] rd_key;
    logic [127:0] store [NRK];

    logic [7:0]   rcon;
    logic [23:0]  unused_rcon;
    logic [31:0]  rot;
    logic [31:0]  sub;
    logic [31:0]  t;
    logic [31:0]  n0, n1, n2, n3;

    logic         wr_en;
    logic [3:0]   wr_idx;
    logic [127:0] wr_dat;

    // Only the top byte of the rcon word carries the round constant.
    assign rcon        = bus.rcon_in[31:24];
    assign unused_rcon = bus.rcon_in[23:0];

    // The rcon generator must load on the very same edge we sample the key.
    assign bus.kld_o = bus.key_ld & ~rst;

    assign rot = {w[23:0], w[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot[8*i +: 8]),
            .y (sub[8*i +: 8])
        );
    end

    assign t     = sub ^ {rcon, 24'h000000};
    assign n0    = w[127:96] ^ t;
    assign n1    = w[95:64]  ^ n0;
    assign n2    = w[63:32]  ^ n1;
    assign n3    = w[31:0]   ^ n2;
    assign w_nxt = {n0, n1, n2, n3};

    // Sequencer: load restarts from any state, reset wins over load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            w     <= '0;
            rnd   <= '0;
            vld   <= 1'b0;
            busy  <= 1'b0;
            kdone <= 1'b0;
        end else if (bus.key_ld) begin
            state <= GEN;
            w     <= bus.key_in;
            rnd   <= '0;
            vld   <= 1'b1;
            busy  <= 1'b1;
            kdone <= 1'b0;
        end else begin
            case (state)
                GEN: begin
                    w   <= w_nxt;
                    rnd <= rnd + 4'd1;
                    vld <= 1'b1;
                    if (rnd == 4'(NRK - 2)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        kdone <= 1'b1;
                    end
                end
                default: begin
                    vld <= 1'b0;
                end
            endcase
        end
    end

    // Store write select: the loaded key goes to entry 0, each new round key to rnd+1.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        wr_dat = w_nxt;
        if (!rst) begin
            if (bus.key_ld) begin
                wr_en  = 1'b1;
                wr_dat = bus.key_in;
            end else if (state == GEN) begin
                wr_en  = 1'b1;
                wr_idx = rnd + 4'd1;
            end
        end
    end

    // Round-key store; deliberately not cleared so it needs no reset network.
    always_ff @(posedge clk) begin
        if (wr_en) store[wr_idx] <= wr_dat;
    end

    // Registered read; same-edge write is not forwarded, so the old entry is returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_key <= '0;
        end else if (bus.rd_idx < 4'(NRK)) begin
            rd_key <= store[bus.rd_idx];
        end else begin
            rd_key <= '0;
        end
    end

    assign bus.rk_o     = w;
    assign bus.rk_vld_o = vld;
    assign bus.rk_idx_o = rnd;
    assign bus.busy_o   = busy;
    assign bus.kdone_o  = kdone;
    assign bus.rd_key_o = rd_key;
endmodule

// File: tb/tb_aes_key_sched.sv
// Randomised and directed bench for aes_key_sched with a scoreboarded round-key stream.
// Stimulus changes on the falling edge; outputs are sampled 1 time unit after the rising edge.
// The rcon source is modelled as a register that loads 0x01 on kld_o and doubles in GF(2^8).
module tb_aes_key_sched;
    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk;
    logic rst;
    logic [7:0] rc_q;

    aes_key_sched_if bus ();

    aes_key_sched #(.NRK(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    exp_t         exp_q[$];
    logic [127:0] model_store [16];
    logic [127:0] ref_rk [11];
    logic [7:0]   sbox_t [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Upstream round-constant generator; low 24 bits carry junk that must be ignored.
    always @(posedge clk) begin
        if (rst)            rc_q <= 8'h00;
        else if (bus.kld_o) rc_q <= 8'h01;
        else                rc_q <= xtime(rc_q);
    end
    assign bus.rcon_in = {rc_q, 24'h5a5a5a};

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // S-box from exp/log tables of generator 3 and the bitwise FIPS affine form.
    task automatic build_sbox();
        logic [7:0] exp_t [256];
        logic [7:0] log_t [256];
        logic [7:0] x;
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        int li;
        x = 8'h01;
        log_t[0] = 8'h00;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = 8'(i);
            x = x ^ xtime(x);
        end
        c = 8'h63;
        for (int v = 0; v < 256; v++) begin
            if (v == 0) begin
                inv = 8'h00;
            end else begin
                li  = int'(log_t[v]);
                inv = exp_t[(255 - li) % 255];
            end
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8]
                     ^ inv[(b + 7) % 8] ^ c[b];
            sbox_t[v] = s;
        end
    endtask

    // Textbook 44-word expansion, grouped into 11 round keys.
    task automatic expand(input logic [127:0] key);
        logic [31:0] wd [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) wd[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = wd[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
                      ^ {rc, 24'h000000};
                rc  = xtime(rc);
            end
            wd[i] = wd[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) ref_rk[r] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
    endtask

    // Issues a one-cycle load; returns on the falling edge after the load edge.
    task automatic load_key(input logic [127:0] k);
        expand(k);
        @(negedge clk);
        bus.key_in = k;
        bus.key_ld = 1'b1;
        exp_q.delete();
        for (int r = 0; r < 11; r++) exp_q.push_back(exp_t'{idx: 4'(r), key: ref_rk[r]});
        #1;
        check("kld_on_load", {127'b0, bus.kld_o}, 128'd1);
        @(negedge clk);
        bus.key_ld = 1'b0;
    endtask

    task automatic wait_idx(input int k);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            @(negedge clk);
            if (bus.rk_vld_o === 1'b1 && bus.rk_idx_o == 4'(k)) hit = 1'b1;
        end
        if (!hit) timeout_fail("wait_idx");
    endtask

    task automatic drain();
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) timeout_fail("drain");
        @(negedge clk);
    endtask

    task automatic read_check(input int i);
        @(negedge clk);
        bus.rd_idx = 4'(i);
        @(posedge clk);
        #1;
        check($sformatf("rd_key[%0d]", i), bus.rd_key_o, (i <= 10) ? model_store[i] : 128'h0);
    endtask

    // Monitor: pops the scoreboard on every valid round key.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rk_vld_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_extra: rk_vld_o=1 idx=%0d with no key expected", bus.rk_idx_o);
                end else begin
                    e = exp_q.pop_front();
                    check("rk_idx", {124'b0, bus.rk_idx_o}, {124'b0, e.idx});
                    check("rk_key", bus.rk_o, e.key);
                    check("busy_gen", {127'b0, bus.busy_o}, {127'b0, e.idx != 4'd10});
                    check("kdone_gen", {127'b0, bus.kdone_o}, {127'b0, e.idx == 4'd10});
                    model_store[e.idx] = e.key;
                end
            end else begin
                check("busy_idle", {127'b0, bus.busy_o}, 128'd0);
            end
        end
    end

    initial begin
        logic [127:0] k;
        logic [127:0] old4;
        logic [127:0] new4;
        int seen;

        build_sbox();
        rst        = 1'b1;
        bus.key_ld = 1'b0;
        bus.key_in = '0;
        bus.rd_idx = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rk", bus.rk_o, 128'h0);
        check("rst_vld", {127'b0, bus.rk_vld_o}, 128'd0);
        check("rst_idx", {124'b0, bus.rk_idx_o}, 128'd0);
        check("rst_kdone", {127'b0, bus.kdone_o}, 128'd0);
        check("rst_rd_key", bus.rd_key_o, 128'h0);
        check("rst_kld", {127'b0, bus.kld_o}, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 vector and done timing
        load_key(FIPS_KEY);
        check("kdone_after_e0", {127'b0, bus.kdone_o}, 128'd0);
        seen = 0;
        for (int c = 1; c <= 20 && seen == 0; c++) begin
            @(negedge clk);
            if (bus.kdone_o === 1'b1) seen = c;
        end
        check("kdone_edge", 128'(seen), 128'd10);
        check("fips_r10", bus.rk_o, FIPS_R10);
        drain();

        // Readback sweep including out-of-range indices
        for (int i = 0; i < 16; i++) read_check(i);
        @(negedge clk);
        bus.rd_idx = 4'd1;
        @(posedge clk);
        #1;
        check("fips_r1_store", bus.rd_key_o, FIPS_R1);

        // Restart mid-generation
        load_key({$urandom, $urandom, $urandom, $urandom});
        wait_idx(5);
        load_key(SEQ_KEY);
        check("restart_idx", {124'b0, bus.rk_idx_o}, 128'd0);
        check("restart_rk0", bus.rk_o, SEQ_KEY);
        drain();
        check("seq_r10", bus.rk_o, SEQ_R10);

        // Reset during generation
        load_key(FIPS_KEY);
        wait_idx(3);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("mid_rst_rk", bus.rk_o, 128'h0);
        check("mid_rst_vld", {127'b0, bus.rk_vld_o}, 128'd0);
        check("mid_rst_idx", {124'b0, bus.rk_idx_o}, 128'd0);
        check("mid_rst_kdone", {127'b0, bus.kdone_o}, 128'd0);
        check("mid_rst_rd_key", bus.rd_key_o, 128'h0);
        check("mid_rst_kld", {127'b0, bus.kld_o}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        load_key(FIPS_KEY);
        drain();
        check("fips_again_r10", bus.rk_o, FIPS_R10);

        // Reset and load on the same edge
        @(negedge clk);
        rst        = 1'b1;
        bus.key_ld = 1'b1;
        bus.key_in = {$urandom, $urandom, $urandom, $urandom};
        exp_q.delete();
        #1;
        check("prio_kld", {127'b0, bus.kld_o}, 128'd0);
        @(posedge clk);
        #1;
        check("prio_vld", {127'b0, bus.rk_vld_o}, 128'd0);
        check("prio_busy", {127'b0, bus.busy_o}, 128'd0);
        check("prio_kdone", {127'b0, bus.kdone_o}, 128'd0);
        @(negedge clk);
        rst        = 1'b0;
        bus.key_ld = 1'b0;
        repeat (3) @(negedge clk);

        // Same-edge read and write of entry 4
        old4 = model_store[4];
        bus.rd_idx = 4'd4;
        k = {$urandom, $urandom, $urandom, $urandom};
        load_key(k);
        new4 = ref_rk[4];
        check("rw_k0", bus.rd_key_o, old4);
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            check($sformatf("rw_k%0d", e), bus.rd_key_o, (e <= 4) ? old4 : new4);
        end
        drain();

        // Random keys, some restarted part way through
        for (int n = 0; n < 6; n++) begin
            load_key({$urandom, $urandom, $urandom, $urandom});
            if (n % 2 == 1) begin
                wait_idx($urandom_range(1, 9));
                load_key({$urandom, $urandom, $urandom, $urandom});
            end
            drain();
            for (int j = 0; j < 3; j++) read_check($urandom_range(0, 15));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
